// File: rtl/screen_write_scheduler.sv
// Command FIFO, cursor and clear engine for the character screen memory.
// Writes are only issued while the raster is outside the visible area.
module screen_write_scheduler #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 40,
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  HorizontalCounter,
    input  logic [9:0]  VerticalCounter,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [1:0]  host_cmd,
    input  logic [11:0] host_data,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [11:0] cursor,
    output logic        busy
);

    localparam int          DEPTH    = COLS * ROWS;
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [11:0] DEPTH_W  = 12'(DEPTH);
    localparam logic [11:0] LAST     = 12'(DEPTH - 1);
    localparam logic [9:0]  H_LIM    = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [13:0]   fifo_q [FIFO_DEPTH];
    logic [13:0]   fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [11:0]   clr_cnt_q, clr_cnt_d;
    logic [11:0]   cursor_q, cursor_d;
    logic          mem_we_q, mem_we_d;
    logic [11:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;

    logic          blank, full, empty, push, pop;
    logic [1:0]    head_cmd;
    logic [11:0]   head_data;

    assign blank     = (HorizontalCounter >= H_LIM) || (VerticalCounter >= V_LIM);
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign push      = host_valid && !full;
    assign head_cmd  = fifo_q[rd_ptr_q][13:12];
    assign head_data = fifo_q[rd_ptr_q][11:0];

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        cursor_d    = cursor_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    case (head_cmd)
                        2'b00: begin
                            // Character writes wait for blanking; the queue stalls behind them.
                            if (blank) begin
                                pop         = 1'b1;
                                mem_we_d    = 1'b1;
                                mem_addr_d  = cursor_q;
                                mem_wdata_d = head_data[7:0];
                                cursor_d    = (cursor_q == LAST) ? '0 : cursor_q + 12'd1;
                            end
                        end
                        2'b01: begin
                            pop      = 1'b1;
                            cursor_d = (head_data < DEPTH_W) ? head_data : '0;
                        end
                        2'b10: begin
                            pop       = 1'b1;
                            clr_cnt_d = '0;
                            state_d   = CLEAR;
                        end
                        default: pop = 1'b1;
                    endcase
                end
            end
            CLEAR: begin
                if (blank) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = clr_cnt_q;
                    mem_wdata_d = FILL_CHAR;
                    clr_cnt_d   = clr_cnt_q + 12'd1;
                    if (clr_cnt_q == LAST) begin
                        cursor_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {host_cmd, host_data};
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            clr_cnt_q   <= '0;
            cursor_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            clr_cnt_q   <= clr_cnt_d;
            cursor_q    <= cursor_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign host_ready = !full;
    assign busy       = !empty || (state_q == CLEAR);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cursor     = cursor_q;

endmodule

// File: tb/tb_screen_write_scheduler.sv
// Bench for screen_write_scheduler: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_screen_write_scheduler;

    localparam int DEPTH = 3200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  hc = '0;
    logic [9:0]  vc = '0;
    logic        host_valid = 1'b0;
    logic [1:0]  host_cmd = '0;
    logic [11:0] host_data = '0;
    logic        host_ready, mem_we, busy;
    logic [11:0] mem_addr, cursor;
    logic [7:0]  mem_wdata;

    always #5 clk = ~clk;

    screen_write_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .HorizontalCounter(hc), .VerticalCounter(vc),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_cmd(host_cmd), .host_data(host_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cursor(cursor), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: commands as a plain queue, clear as a counter.
    logic [13:0] mq[$];
    bit m_clr;
    int m_cnt, m_cur, m_addr, m_data;
    bit m_we;

    task automatic model_reset();
        mq.delete();
        m_clr = 0; m_cnt = 0; m_cur = 0;
        m_we = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic model_step();
        bit blank = (hc >= 640) || (vc >= 480);
        bit room = (mq.size() < 4);
        m_we = 0;
        if (m_clr) begin
            if (blank) begin
                m_we = 1; m_addr = m_cnt; m_data = 32;
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_clr = 0;
                    m_cur = 0;
                end
            end
        end else if (mq.size() > 0) begin
            logic [1:0] c;
            int d;
            c = mq[0][13:12];
            d = int'(mq[0][11:0]);
            if (c == 2'b00) begin
                if (blank) begin
                    void'(mq.pop_front());
                    m_we = 1; m_addr = m_cur; m_data = d % 256;
                    m_cur = (m_cur + 1) % DEPTH;
                end
            end else begin
                void'(mq.pop_front());
                if (c == 2'b01) m_cur = (d < DEPTH) ? d : 0;
                else if (c == 2'b10) begin
                    m_clr = 1;
                    m_cnt = 0;
                end
            end
        end
        if (host_valid && room) mq.push_back({host_cmd, host_data});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    int wr_count = 0;
    int waddr[$];
    int wdata[$];

    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_data);
            chk("cursor", cursor, m_cur);
            chk("busy", busy, (mq.size() != 0) || m_clr);
            chk("host_ready", host_ready, mq.size() < 4);
            if (mem_we === 1'b1) begin
                wr_count++;
                waddr.push_back(int'(mem_addr));
                wdata.push_back(int'(mem_wdata));
            end
        end
    end

    task automatic push(input logic [1:0] c, input logic [11:0] d);
        int n = 0;
        @(negedge clk);
        host_valid = 1'b1; host_cmd = c; host_data = d;
        while (!host_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        host_valid = 1'b0;
        if (n >= 50) chk("push_timeout", n, 0);
    endtask

    task automatic wait_we(input int maxc, output int n);
        n = 0;
        while (mem_we !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_we", mem_we, 1);
    endtask

    task automatic wait_idle(input int maxc, input bit toggle);
        int n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
            if (toggle) vc = ((n / 9) % 2 == 1) ? 10'd100 : 10'd500;
        end
        chk("clear_done", busy, 0);
    endtask

    task automatic check_clear();
        int bad = 0;
        chk("clear_writes", waddr.size(), DEPTH);
        for (int i = 0; i < waddr.size(); i++)
            if (waddr[i] != i || wdata[i] != 32) bad++;
        chk("clear_sequence", bad, 0);
        chk("clear_cursor", cursor, 0);
    endtask

    initial begin
        int n;
        bit [4:0] rdy;

        // 1: reset mid-frame
        hc = 10'd300; vc = 10'd200;
        repeat (3) @(negedge clk);
        chk("rst_we", mem_we, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", host_ready, 1);
        chk("rst_addr", mem_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", host_ready, 1);

        // 2: set cursor then write during blank
        hc = 10'd700; vc = 10'd10;
        push(2'b01, 12'd100);
        push(2'b00, 12'h041);
        wait_we(10, n);
        chk("latency", n, 1);
        chk("t2_addr", mem_addr, 100);
        chk("t2_data", mem_wdata, 8'h41);
        chk("t2_cursor", cursor, 101);
        @(negedge clk);
        chk("t2_single_pulse", mem_we, 0);

        // 3: write held off by the active area
        hc = 10'd100; vc = 10'd100;
        n = wr_count;
        push(2'b00, 12'h042);
        repeat (20) @(negedge clk);
        chk("t3_no_write", wr_count - n, 0);
        chk("t3_busy", busy, 1);
        hc = 10'd640;
        wait_we(5, n);
        chk("t3_addr", mem_addr, 101);
        chk("t3_data", mem_wdata, 8'h42);
        chk("t3_cursor", cursor, 102);

        // 4: wrap at the last cell, reserved cmd, out-of-range set
        waddr.delete(); wdata.delete();
        push(2'b01, 12'd3199);
        push(2'b11, 12'h05A);
        push(2'b00, 12'h058);
        push(2'b00, 12'h059);
        repeat (5) @(negedge clk);
        chk("t4_writes", waddr.size(), 2);
        if (waddr.size() >= 2) begin
            chk("t4_addr0", waddr[0], 3199);
            chk("t4_data0", wdata[0], 8'h58);
            chk("t4_addr1", waddr[1], 0);
            chk("t4_data1", wdata[1], 8'h59);
        end
        chk("t4_cursor", cursor, 1);
        push(2'b01, 12'd4000);
        repeat (3) @(negedge clk);
        chk("t4_bad_set", cursor, 0);

        // 5: clear with blank held, then with periodic active intervals
        push(2'b01, 12'd55);
        repeat (3) @(negedge clk);
        chk("t5_cursor_set", cursor, 55);
        hc = 10'd0; vc = 10'd500;
        waddr.delete(); wdata.delete();
        push(2'b10, 12'd0);
        wait_idle(4000, 1'b0);
        check_clear();
        push(2'b01, 12'd7);
        waddr.delete(); wdata.delete();
        push(2'b10, 12'd0);
        wait_idle(12000, 1'b1);
        check_clear();
        vc = 10'd500;

        // 6: FIFO full while stalled, then reset mid-clear
        hc = 10'd100; vc = 10'd100;
        @(negedge clk);
        chk("t6_empty", busy, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            host_valid = 1'b1; host_cmd = 2'b00; host_data = 12'(48 + i);
            rdy[i] = host_ready;
        end
        @(negedge clk);
        host_valid = 1'b0;
        chk("t6_ready_pattern", rdy, 5'b01111);
        chk("t6_full", host_ready, 0);
        waddr.delete(); wdata.delete();
        vc = 10'd500;
        repeat (10) @(negedge clk);
        chk("t6_drained", waddr.size(), 4);
        if (waddr.size() >= 4) begin
            chk("t6_last_addr", waddr[3], 3);
            chk("t6_last_data", wdata[3], 8'h33);
        end
        push(2'b10, 12'd0);
        repeat (100) @(negedge clk);
        push(2'b01, 12'd9);
        chk("t6_busy_clear", busy, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", host_ready, 1);
        chk("t6_rst_cursor", cursor, 0);
        chk("t6_rst_we", mem_we, 0);
        rst_n = 1'b1;
        waddr.delete(); wdata.delete();
        repeat (50) @(negedge clk);
        chk("t6_no_resume", waddr.size(), 0);
        chk("t6_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
